// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock.
// Shares the addsub block with the multiplier for its trial subtraction.

module addsub #(
    parameter int width = 9
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             add_sub,
    output logic [width-1:0] result
);

    // add_sub = 1 adds, add_sub = 0 subtracts
    always_comb begin
        result = add_sub ? (a + b) : (a - b);
    end

endmodule

module seq_divider #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [dw-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [dw-1:0] quotient,
    output logic [dw-1:0] remainder,
    output logic          div_by_zero
);

    localparam int cw = $clog2(dw + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Partial remainder stays below D, so its top (dw+1)th bit is always
    // zero and only the low dw bits are kept.
    logic [dw-1:0] r;
    logic [dw-1:0] q;
    logic [dw-1:0] d;
    logic [cw-1:0] cnt;

    logic [dw:0]   s;
    logic [dw:0]   t;
    logic [dw-1:0] r_next;
    logic [dw-1:0] q_next;
    logic          accept;
    logic          zero_div;
    logic          last;

    addsub #(
        .width(dw + 1)
    ) u_sub (
        .a      (s),
        .b      ({1'b0, d}),
        .add_sub(1'b0),
        .result (t)
    );

    // Trial subtraction step and handshake decode
    always_comb begin
        s        = {r, q[dw-1]};
        r_next   = t[dw] ? s[dw-1:0] : t[dw-1:0];
        q_next   = {q[dw-2:0], ~t[dw]};
        accept   = start && (state == IDLE || state == DONE);
        zero_div = (divisor == '0);
        last     = (cnt == cw'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = zero_div ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: load on accept, shift/subtract during CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (accept && !zero_div) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= cw'(dw);
        end else if (state == CALC) begin
            r   <= r_next;
            q   <= q_next;
            cnt <= cnt - cw'(1);
        end
    end

    // Result registers change only on completion edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (state == CALC && last) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed and random divisions
// checked against plain / and % arithmetic.

module tb_seq_divider;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] last_q = '0;
    logic [DW-1:0] last_r = '0;

    seq_divider #(
        .dw(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input int a, input int b,
                                    output int eq, output int er,
                                    output int ez);
        if (b == 0) begin
            eq = (1 << DW) - 1;
            er = a;
            ez = 1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 0;
        end
    endfunction

    // Wait for done; results must hold and busy stay high meanwhile
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            check("busy", busy, 1);
            check("hold_q", quotient, last_q);
            check("hold_r", remainder, last_r);
            tick;
            lat++;
        end
        check("done_seen", done, 1);
        check("excl", busy & done, 0);
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int eq, er, ez;
        ref_div(a, b, eq, er, ez);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_z"}, div_by_zero, ez);
        last_q = eq[DW-1:0];
        last_r = er[DW-1:0];
    endtask

    task automatic do_op(input string tag, input int a, input int b);
        int lat;
        dividend = a[DW-1:0];
        divisor  = b[DW-1:0];
        start    = 1'b1;
        tick;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = DW'($urandom);
        wait_done(lat);
        check({tag, "_lat"}, lat, (b == 0) ? 0 : DW);
        check_result(tag, a, b);
        tick;
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int lat, lat2, a, b;

        repeat (2) tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_z", div_by_zero, 0);
        rst_n = 1'b1;
        tick;

        do_op("basic", 100, 7);
        repeat (3) tick;
        check("basic_hold_q", quotient, 14);
        check("basic_hold_r", remainder, 2);

        do_op("e255_1", 255, 1);
        do_op("e255_255", 255, 255);
        do_op("e3_200", 3, 200);
        do_op("e0_9", 0, 9);

        do_op("dz", 5, 0);
        do_op("after_dz", 200, 16);

        // Back-to-back: start held through the DONE cycle
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        wait_done(lat);
        check_result("b2b1", 100, 7);
        dividend = 8'd77;
        divisor  = 8'd10;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        check("b2b_noidle", busy, 1);
        wait_done(lat2);
        check("b2b_gap", lat2 + 1, 9);
        check_result("b2b2", 77, 10);
        tick;
        check("b2b_pulse", done, 0);

        // Start during CALC is ignored
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        repeat (2) tick;
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        wait_done(lat);
        check("ign_lat", lat + 3, DW);
        check_result("ign", 100, 7);
        tick;
        check("ign_pulse1", done, 0);
        tick;
        check("ign_pulse2", done, 0);

        // Asynchronous reset mid-operation
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_q", quotient, 0);
        check("mid_r", remainder, 0);
        check("mid_z", div_by_zero, 0);
        last_q = '0;
        last_r = '0;
        repeat (3) begin
            tick;
            check("mid_nodone", done, 0);
        end
        rst_n = 1'b1;
        tick;
        do_op("post_rst", 9, 4);

        // Random operands, some with zero divisor
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0
                : int'($urandom_range(1, 255));
            do_op("rand", a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned integer divider: the inverse of the datapath's multiply path. It computes quotient and remainder of two `dw`-bit operands with a restoring shift/subtract algorithm, one quotient bit per clock. It sits beside the sequential multiplier and reuses the `addsub` block, at width `dw+1` with `add_sub` tied 0, for its trial subtraction. A start/busy/done handshake connects it to the lab controller.

## Interface

**Parameters**
- `dw`, default 8: operand and result data width, ≥ 2.

**Ports**
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Sampled only in IDLE or DONE.
- `dividend`, input, `dw`: numerator. Captured on the accepting edge.
- `divisor`, input, `dw`: denominator. Captured on the accepting edge.
- `busy`, output, 1: high while in CALC.
- `done`, output, 1: one-cycle pulse; results are valid.
- `quotient`, output, `dw`: registered result. Holds until the next completion.
- `remainder`, output, `dw`: registered result. Holds until the next completion.
- `div_by_zero`, output, 1: registered flag for the last completed operation.

## Operation

**States:** IDLE, CALC, DONE.

**Reset** (asserted, any state, takes effect immediately):
- State returns to IDLE.
- `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
- Internal R, Q, divisor register and counter = 0.
- An operation in flight is aborted; no `done` is produced for it.

**IDLE or DONE with `start`=1, divisor ≠ 0:**
- Capture divisor into D.
- Load Q = dividend and R = 0 (`dw+1` bits).
- Load counter = `dw`.
- Go to CALC.

**IDLE or DONE with `start`=1, divisor = 0:**
- Load `quotient` = all ones and `remainder` = dividend.
- Set `div_by_zero` = 1.
- Go to DONE. No CALC cycles.

**IDLE or DONE with `start`=0:**
- DONE goes to IDLE.
- IDLE stays in IDLE.

**CALC, each edge:**
- S = {R[dw-1:0], Q[dw-1]}.
- T = S − {1'b0, D}, computed at width `dw+1`.
- If T[dw] = 0: R ← T, Q ← {Q[dw-2:0], 1}.
- Else: R ← S, Q ← {Q[dw-2:0], 0}.
- Decrement the counter.
- On the edge where the counter goes 1→0:
  - Load `quotient` ← new Q and `remainder` ← new R[dw-1:0].
  - Set `div_by_zero` ← 0.
  - Go to DONE.

**Other rules:**
- `start` while in CALC is ignored. No queuing, no restart.
- Operand inputs may change freely after the accepting edge.
- All arithmetic is unsigned.
- The remainder always satisfies remainder < divisor, and dividend = quotient·divisor + remainder.

## Timing

- Outputs are Moore: `busy` = (state == CALC), `done` = (state == DONE).
- **Normal latency:** `start` sampled at edge E0 → CALC during edges E1..E`dw` → `done`=1 in the cycle after edge E`dw`. That is `dw` edges after acceptance; 8 for `dw`=8.
- **Divide-by-zero latency:** `done`=1 in the cycle immediately after E0.
- **Back-to-back:** `start` high during the DONE cycle is accepted. Sustained throughput is one result per `dw+1` cycles.
- Result outputs change only on completion edges (or at reset). They are stable while `busy`=1 and while idle.
- `done` is never high for more than one consecutive cycle per accepted operation.
- `busy` and `done` are never high together.

## Test plan

All scenarios use `dw`=8.

- **Basic division:** reset, then `start` with 100 / 7 → `busy`=1 for 8 cycles, then `done` pulse with `quotient`=14, `remainder`=2, `div_by_zero`=0. Outputs hold 14/2 afterwards.
- **Edge operands:**
  - 255 / 1 → 255 r 0.
  - 255 / 255 → 1 r 0.
  - 3 / 200 → 0 r 3.
  - 0 / 9 → 0 r 0.
  - Each completes exactly 8 edges after acceptance.
- **Divide by zero:** 5 / 0 → `done` the cycle after acceptance, `quotient`=255, `remainder`=5, `div_by_zero`=1, `busy` never asserted. A following 200 / 16 returns 12 r 8 and clears `div_by_zero`.
- **Back-to-back:** hold `start` through the DONE cycle with new operands 77 / 10 → accepted with no IDLE cycle; the second `done` arrives 9 cycles after the first with 7 r 7.
- **Start during CALC:** pulse `start` with 50 / 5 during cycle 3 of an in-progress 100 / 7 → ignored; result is 14 r 2, and exactly one `done` pulse.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously in cycle 4 of CALC → all outputs 0 immediately, no `done`. After release, 9 / 4 → 2 r 1.
